// File: rtl/weight_load_if.sv
// weight_load_if: command, weight-memory and FIFO-column signals of the weight load sequencer.
interface weight_load_if #(parameter int ADDR_W = 8);
  logic start, abort, busy, done, mem_rd_en, weight_load_start, pop;
  logic [ADDR_W-1:0] base_addr, mem_addr;
  logic [23:0] mem_rdata;
  logic push_col0, push_col1, push_col2;
  logic [7:0] data_col0, data_col1, data_col2;
  modport master (
    input start, base_addr, abort, mem_rdata,
    output busy, done, mem_rd_en, mem_addr, weight_load_start, pop,
    output push_col0, push_col1, push_col2, data_col0, data_col1, data_col2
  );
  modport slave (
    output start, base_addr, abort, mem_rdata,
    input busy, done, mem_rd_en, mem_addr, weight_load_start, pop,
    input push_col0, push_col1, push_col2, data_col0, data_col1, data_col2
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: resyncs the 3-column weight FIFO, fills it from weight memory, then pops it into the MMU.
module weight_load_ctrl #(
  parameter int ADDR_W = 8,
  parameter int ROWS = 3,
  parameter int READ_LATENCY = 1,
  parameter int POP_CYCLES = 7
) (
  input logic clk,
  input logic rst_n,
  weight_load_if.master bus
);
  localparam int CNT_W = $clog2((ROWS > POP_CYCLES ? ROWS : POP_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, CLR, RD, WAIT, POP, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [READ_LATENCY-1:0] vld, vld_nxt;
  logic busy, done, rd_en, wls, pop, kill, push;
  assign kill = bus.abort && state != IDLE;
  // vld tracks reads in flight; its top bit marks the cycle mem_rdata is valid
  assign vld_nxt = kill ? '0 : READ_LATENCY'({vld, rd_en});
  assign push = vld[READ_LATENCY-1];
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.start ? CLR : IDLE;
      CLR: nxt = RD;
      RD: nxt = cnt == CNT_W'(ROWS - 1) ? WAIT : RD;
      WAIT: nxt = vld_nxt == '0 ? POP : WAIT;
      POP: nxt = cnt == CNT_W'(POP_CYCLES - 1) ? DONE : POP;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      vld <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_en <= 1'b0;
      wls <= 1'b0;
      pop <= 1'b0;
    end else begin
      state <= nxt;
      vld <= vld_nxt;
      cnt <= nxt == state ? cnt + 1'b1 : '0;
      addr <= state == IDLE ? bus.base_addr : state == RD ? addr + 1'b1 : addr;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      rd_en <= nxt == RD;
      wls <= nxt == CLR;
      pop <= nxt == POP;
    end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr = addr;
  assign bus.weight_load_start = wls;
  assign bus.pop = pop;
  assign bus.push_col0 = push;
  assign bus.push_col1 = push;
  assign bus.push_col2 = push;
  assign bus.data_col0 = push ? bus.mem_rdata[7:0] : '0;
  assign bus.data_col1 = push ? bus.mem_rdata[15:8] : '0;
  assign bus.data_col2 = push ? bus.mem_rdata[23:16] : '0;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed cycle-by-cycle checks of weight_load_ctrl at read latency 1 and 3.
module tb_weight_load_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic [23:0] mem [256];
  logic [23:0] q1, p0, p1, p2;
  logic [23:0] exp_row [3];
  logic [7:0] f1, f3;
  logic [23:0] d1, d3;
  weight_load_if #(.ADDR_W(8)) b1 ();
  weight_load_if #(.ADDR_W(8)) b3 ();
  weight_load_ctrl #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  weight_load_ctrl #(.READ_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  always @(posedge clk) begin
    q1 <= mem[b1.mem_addr];
    p0 <= mem[b3.mem_addr];
    p1 <= p0;
    p2 <= p1;
  end
  assign b1.mem_rdata = q1;
  assign b3.mem_rdata = p2;
  assign f1 = {b1.busy, b1.done, b1.mem_rd_en, b1.weight_load_start, b1.pop, b1.push_col0, b1.push_col1, b1.push_col2};
  assign f3 = {b3.busy, b3.done, b3.mem_rd_en, b3.weight_load_start, b3.pop, b3.push_col0, b3.push_col1, b3.push_col2};
  assign d1 = {b1.data_col2, b1.data_col1, b1.data_col0};
  assign d3 = {b3.data_col2, b3.data_col1, b3.data_col0};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, o, e);
    end
  endtask

  task automatic drive(input bit s, input logic st, input logic ab);
    if (s) begin
      b3.start = st;
      b3.abort = ab;
    end else begin
      b1.start = st;
      b1.abort = ab;
    end
  endtask

  // one load on dut1 (s=0) or dut3 (s=1); flags packed {busy,done,rd,wls,pop,push x3}
  task automatic load(input bit s, input logic [7:0] base, input int ab_at, input int rst_at,
                      input int pulse_at, input int hold_from, input bit ab0, input int ncyc);
    int l, last;
    logic [7:0] ef, f, a, ea;
    logic [23:0] d;
    bit act, rd, pu;
    l = s ? 3 : 1;
    last = ab_at != 0 ? ab_at : rst_at != 0 ? rst_at - 1 : 1000;
    if (s) b3.base_addr = base;
    else b1.base_addr = base;
    drive(s, 1'b1, ab0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
      end
      act = c <= last;
      rd = act && c >= 2 && c <= 4;
      pu = act && c >= 2 + l && c <= 4 + l;
      ef = {act && c <= 12 + l, act && c == 12 + l, rd, act && c == 1,
            act && c >= 5 + l && c <= 11 + l, pu, pu, pu};
      f = s ? f3 : f1;
      a = s ? b3.mem_addr : b1.mem_addr;
      d = s ? d3 : d1;
      chk($sformatf("L%0d c%0d flags", l, c), 32'(f), 32'(ef));
      ea = base + 8'(c - 2);
      if (rd) chk($sformatf("L%0d c%0d addr", l, c), 32'(a), 32'(ea));
      if (pu) chk($sformatf("L%0d c%0d data", l, c), 32'(d), 32'(exp_row[c - 2 - l]));
      if (c == rst_at) chk("reset addr", 32'(a), 32'h0);
      drive(s, c == pulse_at || (hold_from != 0 && c >= hold_from), c == ab_at);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 24'h0;
    mem[8'h10] = 24'h030201;
    mem[8'h11] = 24'h060504;
    mem[8'h12] = 24'h090807;
    mem[8'hFE] = 24'hAABBCC;
    mem[8'hFF] = 24'h112233;
    mem[8'h00] = 24'h445566;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    b1.base_addr = 8'h0;
    b3.base_addr = 8'h0;
    #12;
    chk("reset flags L1", 32'(f1), 32'h0);
    chk("reset flags L3", 32'(f3), 32'h0);
    chk("reset addr L1", 32'(b1.mem_addr), 32'h0);
    chk("reset data L1", 32'(d1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_row = '{24'h030201, 24'h060504, 24'h090807};
    load(0, 8'h10, 0, 0, 0, 0, 0, 14);
    load(1, 8'h10, 0, 0, 0, 0, 0, 16);
    exp_row = '{24'hAABBCC, 24'h112233, 24'h445566};
    load(0, 8'hFE, 0, 0, 0, 0, 0, 14);
    exp_row = '{24'h030201, 24'h060504, 24'h090807};
    load(0, 8'h10, 0, 0, 4, 13, 0, 14);
    load(0, 8'h10, 0, 0, 0, 0, 0, 14);
    load(0, 8'h10, 4, 0, 0, 0, 0, 8);
    load(0, 8'h10, 0, 0, 0, 0, 1, 14);
    load(0, 8'h10, 0, 8, 0, 0, 0, 10);
    @(negedge clk);
    rst_n = 1'b1;
    load(0, 8'h10, 0, 0, 0, 0, 0, 14);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
